// File: rtl/mux_sw_debounce.sv
// Input conditioning for the 4-to-1 2-bit key mux: two-flop synchronisers and
// per-bit debounce counters for the 10 board switches, registered outputs only.
module mux_sw_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [9:0] sw,
  output logic [1:0] x0,
  output logic [1:0] x1,
  output logic [1:0] x2,
  output logic [1:0] x3,
  output logic [1:0] y,
  output logic       chg
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [9:0]       s1;
  logic [9:0]       s2;
  logic [9:0]       db;
  logic [9:0]       db_next;
  logic [CNT_W-1:0] cnt      [10];
  logic [CNT_W-1:0] cnt_next [10];

  // A bit that matches its debounced value forgets any partial count, so a
  // glitch shorter than the window leaves no trace.
  always_comb begin
    db_next = db;
    for (int i = 0; i < 10; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == db[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i]  = s2[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      db  <= '0;
      chg <= 1'b0;
      cnt <= '{default: '0};
    end else begin
      s1  <= sw;
      s2  <= s1;
      db  <= db_next;
      chg <= |(db_next ^ db);
      cnt <= cnt_next;
    end
  end

  assign x0 = db[1:0];
  assign x1 = db[3:2];
  assign x2 = db[5:4];
  assign x3 = db[7:6];
  assign y  = db[9:8];

endmodule
